// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the elastic pipeline chain and its consumers.
//   PIPE_W_DEF / PIPE_RA_DEF : default payload and register-address widths
//   pipe_entry_t             : one stage entry {valid, wr, wa, data}
//   PIPE_NOP / PIPE_BUBBLE   : payload / entry that a flushed stage degenerates to
//   sat_inc16                : saturating 16-bit increment for statistics counters
package pipe_pkg;

   localparam int PIPE_W_DEF  = 16;
   localparam int PIPE_RA_DEF = 3;

   typedef struct packed {
      logic                   valid;
      logic                   wr;
      logic [PIPE_RA_DEF-1:0] wa;
      logic [PIPE_W_DEF-1:0]  data;
   } pipe_entry_t;

   // Consumers that turn a killed stage into an instruction see an all-zero word.
   localparam logic [PIPE_W_DEF-1:0] PIPE_NOP    = '0;
   localparam pipe_entry_t           PIPE_BUBBLE = '{valid: 1'b0, wr: 1'b0, wa: '0, data: PIPE_NOP};

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one register stage of the elastic chain.
//   clk, rst      : clock, synchronous active-high reset (clears everything)
//   load_i        : stage is free this cycle and takes whatever sits upstream
//                   (an invalid upstream turns the stage into a bubble)
//   kill_i        : flush; the stage is invalid after the edge no matter what
//   up_*_i        : upstream entry (previous stage or the chain input)
//   valid_o..data_o : registered stage contents
module pipe_stage_slot
   import pipe_pkg::*;
#(
   parameter int W  = PIPE_W_DEF,
   parameter int RA = PIPE_RA_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          kill_i,
   input  logic          up_valid_i,
   input  logic          up_wr_i,
   input  logic [RA-1:0] up_wa_i,
   input  logic [W-1:0]  up_data_i,
   output logic          valid_o,
   output logic          wr_o,
   output logic [RA-1:0] wa_o,
   output logic [W-1:0]  data_o
);

   logic          valid_q, valid_d;
   logic          wr_q, wr_d;
   logic [RA-1:0] wa_q, wa_d;
   logic [W-1:0]  data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      wr_d    = wr_q;
      wa_d    = wa_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = up_valid_i;
         // Only copy the tag/payload of a real entry; bubbles leave stale data.
         if (up_valid_i) begin
            wr_d   = up_wr_i;
            wa_d   = up_wa_i;
            data_d = up_data_i;
         end
      end
      if (kill_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         wr_q    <= 1'b0;
         wa_q    <= '0;
         data_q  <= W'(PIPE_NOP);
      end else begin
         valid_q <= valid_d;
         wr_q    <= wr_d;
         wa_q    <= wa_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign wr_o    = wr_q;
   assign wa_o    = wa_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage elastic pipeline between decode and write-back.
//   in_valid/in_ready/in_data/in_wr/in_wa       : upstream handshake into stage 0
//   out_valid/out_ready/out_data/out_wr/out_wa  : stage DEPTH-1, registered outputs
//   flush_mask                                  : bit k empties stage k at the next edge
//   q_addr -> q_hit/q_stage/q_data              : youngest in-flight writer of q_addr
//   occ                                         : registered count of valid stages
//   stat_stall/stat_kill                        : saturating statistics counters,
//                                                 built only with PIPE_STATS_EN defined,
//                                                 tied to 0 otherwise
// Stage 0 is the youngest entry. Bubbles collapse: a stage refills whenever it
// is empty or drains this cycle, so one hole lets everything behind it move.
module pipe_stage_chain
   import pipe_pkg::*;
#(
   parameter int W     = PIPE_W_DEF,
   parameter int DEPTH = 4,
   parameter int RA    = PIPE_RA_DEF,
   parameter int SW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_wr,
   input  logic [RA-1:0]    in_wa,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             out_wr,
   output logic [RA-1:0]    out_wa,
   input  logic [DEPTH-1:0] flush_mask,
   input  logic [RA-1:0]    q_addr,
   output logic             q_hit,
   output logic [SW-1:0]    q_stage,
   output logic [W-1:0]     q_data,
   output logic [SW-1:0]    occ,
   output logic [15:0]      stat_stall,
   output logic [15:0]      stat_kill
);

   logic [DEPTH-1:0] st_valid, st_wr;
   logic [RA-1:0]    st_wa   [DEPTH];
   logic [W-1:0]     st_data [DEPTH];

   logic [DEPTH-1:0] up_valid, up_wr;
   logic [RA-1:0]    up_wa   [DEPTH];
   logic [W-1:0]     up_data [DEPTH];

   // free[k]: stage k may load this cycle (it is empty or its content moves on)
   logic [DEPTH-1:0] free;
   // will_valid[k]: stage k would be valid after the edge if nothing were flushed
   logic [DEPTH-1:0] will_valid;
   logic [DEPTH-1:0] nxt_valid;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign up_valid[gi] = in_valid;
            assign up_wr[gi]    = in_wr;
            assign up_wa[gi]    = in_wa;
            assign up_data[gi]  = in_data;
         end else begin : g_body
            assign up_valid[gi] = st_valid[gi-1];
            assign up_wr[gi]    = st_wr[gi-1];
            assign up_wa[gi]    = st_wa[gi-1];
            assign up_data[gi]  = st_data[gi-1];
         end

         if (gi == DEPTH - 1) begin : g_tail_free
            assign free[gi] = !st_valid[gi] || out_ready;
         end else begin : g_mid_free
            assign free[gi] = !st_valid[gi] || free[gi+1];
         end

         assign will_valid[gi] = free[gi] ? up_valid[gi] : st_valid[gi];
         assign nxt_valid[gi]  = will_valid[gi] && !flush_mask[gi];

         pipe_stage_slot #(
            .W  (W),
            .RA (RA)
         ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load_i     (free[gi]),
            .kill_i     (flush_mask[gi]),
            .up_valid_i (up_valid[gi]),
            .up_wr_i    (up_wr[gi]),
            .up_wa_i    (up_wa[gi]),
            .up_data_i  (up_data[gi]),
            .valid_o    (st_valid[gi]),
            .wr_o       (st_wr[gi]),
            .wa_o       (st_wa[gi]),
            .data_o     (st_data[gi])
         );
      end
   endgenerate

   // The ready chain runs from out_ready back to stage 0; in_valid never enters it.
   assign in_ready  = free[0];

   assign out_valid = st_valid[DEPTH-1];
   assign out_data  = st_data[DEPTH-1];
   assign out_wr    = st_wr[DEPTH-1];
   assign out_wa    = st_wa[DEPTH-1];

   // Occupancy is the population of next-state valid bits, which equals
   // occ + accepted - drained - killed by construction.
   logic [SW-1:0] occ_q, occ_d;

   always_comb begin
      occ_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ_d = occ_d + SW'(nxt_valid[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;

   // Hazard query: scan oldest to youngest so the lowest matching index wins.
   always_comb begin
      q_hit   = 1'b0;
      q_stage = '0;
      q_data  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (st_valid[i] && st_wr[i] && (st_wa[i] == q_addr)) begin
            q_hit   = 1'b1;
            q_stage = SW'(i);
            q_data  = st_data[i];
         end
      end
   end

`ifdef PIPE_STATS_EN
   logic [DEPTH-1:0] killed;
   logic [15:0]      stat_stall_q, stat_kill_q;

   // An entry counts as killed when it would have been valid after the edge,
   // including a freshly accepted entry dropped by flush_mask[0].
   assign killed = will_valid & flush_mask;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_q <= 16'h0000;
         stat_kill_q  <= 16'h0000;
      end else begin
         if (in_valid && !in_ready) begin
            stat_stall_q <= sat_inc16(stat_stall_q);
         end
         if (|killed) begin
            stat_kill_q <= sat_inc16(stat_kill_q);
         end
      end
   end

   assign stat_stall = stat_stall_q;
   assign stat_kill  = stat_kill_q;
`else
   assign stat_stall = 16'h0000;
   assign stat_kill  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed scenarios plus a randomized run against a
// sliding-array model of the chain. Prints one line per accepted / drained entry.
module tb_pipe_stage_chain;

   localparam int W     = 16;
   localparam int DEPTH = 4;
   localparam int RA    = 3;
   localparam int SW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_wr;
   logic [RA-1:0]    in_wa;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic             out_wr;
   logic [RA-1:0]    out_wa;
   logic [DEPTH-1:0] flush_mask;
   logic [RA-1:0]    q_addr;
   logic             q_hit;
   logic [SW-1:0]    q_stage;
   logic [W-1:0]     q_data;
   logic [SW-1:0]    occ;
   logic [15:0]      stat_stall;
   logic [15:0]      stat_kill;

   pipe_stage_chain #(.W(W), .DEPTH(DEPTH), .RA(RA), .SW(SW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_wr      (in_wr),
      .in_wa      (in_wa),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_wr     (out_wr),
      .out_wa     (out_wa),
      .flush_mask (flush_mask),
      .q_addr     (q_addr),
      .q_hit      (q_hit),
      .q_stage    (q_stage),
      .q_data     (q_data),
      .occ        (occ),
      .stat_stall (stat_stall),
      .stat_kill  (stat_kill)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: slot array, index 0 youngest. Each edge: drain, slide every entry
   // into an empty slot ahead of it, accept into slot 0, then apply the flush.
   bit            mv  [DEPTH];
   bit            mwr [DEPTH];
   logic [RA-1:0] mwa [DEPTH];
   logic [W-1:0]  md  [DEPTH];
   int unsigned   m_stall = 0;
   int unsigned   m_kill  = 0;

   function automatic int m_count();
      int n = 0;
      for (int k = 0; k < DEPTH; k++) n += int'(mv[k]);
      return n;
   endfunction

   // A chain with any hole always has room, since holes collapse toward stage 0.
   function automatic bit m_ready();
      return (m_count() < DEPTH) || out_ready;
   endfunction

   function automatic int m_qstage(input logic [RA-1:0] a);
      for (int k = 0; k < DEPTH; k++)
         if (mv[k] && mwr[k] && mwa[k] == a) return k;
      return -1;
   endfunction

   function automatic int unsigned sat16(input int unsigned v);
      return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
   endfunction

   task automatic tick();
      bit rdy;
      int kills;
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) mv[k] = 1'b0;
         m_stall = 0;
         m_kill  = 0;
      end else begin
         rdy   = m_ready();
         kills = 0;
         if (in_valid && !rdy) m_stall = sat16(m_stall);
         if (out_ready && mv[DEPTH-1]) begin
            $display("OUT cyc=%0d data=%h wr=%0b wa=%0d", cyc, md[DEPTH-1], mwr[DEPTH-1], mwa[DEPTH-1]);
            mv[DEPTH-1] = 1'b0;
         end
         for (int k = DEPTH - 2; k >= 0; k--) begin
            if (mv[k] && !mv[k+1]) begin
               mv[k+1] = 1'b1; mwr[k+1] = mwr[k]; mwa[k+1] = mwa[k]; md[k+1] = md[k];
               mv[k] = 1'b0;
            end
         end
         if (in_valid && rdy) begin
            $display("ACC cyc=%0d data=%h wr=%0b wa=%0d flush0=%0b", cyc, in_data, in_wr, in_wa, flush_mask[0]);
            mv[0] = 1'b1; mwr[0] = in_wr; mwa[0] = in_wa; md[0] = in_data;
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (flush_mask[k] && mv[k]) begin
               mv[k] = 1'b0;
               kills++;
            end
         end
         if (kills > 0) m_kill = sat16(m_kill);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_wr = 1'b0; in_wa = '0;
      out_ready = 1'b0; flush_mask = '0; q_addr = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occ); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL reset_q_hit got=%0b exp=0", q_hit); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      checks++; if (stat_stall !== 16'd0 || stat_kill !== 16'd0) begin
         errors++; $display("FAIL reset_stats got=%h/%h exp=0000/0000", stat_stall, stat_kill);
      end
   endtask

   task automatic test_stream();
      logic [W-1:0] exp_d;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = W'(16'h1001 + i);
         #1;
         if (i < 4) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_out i=%0d got=%0b exp=0", i, out_valid); end
            checks++; if (occ !== SW'(i)) begin errors++; $display("FAIL stream_fill_occ i=%0d got=%0d exp=%0d", i, occ, i); end
         end else begin
            exp_d = W'(16'h1001 + i - 4);
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d) begin
               errors++; $display("FAIL stream_out i=%0d got=%0b/%h exp=1/%h", i, out_valid, out_data, exp_d);
            end
            checks++; if (occ !== 3'd4 || in_ready !== 1'b1) begin
               errors++; $display("FAIL stream_steady i=%0d occ=%0d rdy=%0b exp=4/1", i, occ, in_ready);
            end
         end
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int n = 0;
      int guard = 0;
      do_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h2000;
      #1;
      while (in_ready && guard < 10) begin
         tick();
         n++;
         guard++;
         in_data = W'(16'h2000 + n);
         #1;
      end
      checks++; if (n != 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=4", n); end
      checks++; if (occ !== 3'd4 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_full occ=%0d rdy=%0b exp=4/0", occ, in_ready);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1 || out_data !== 16'h2000) begin
         errors++; $display("FAIL bp_release rdy=%0b data=%h exp=1/2000", in_ready, out_data);
      end
      tick();
      out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0 || occ !== 3'd4 || out_data !== 16'h2001) begin
         errors++; $display("FAIL bp_after rdy=%0b occ=%0d data=%h exp=0/4/2001", in_ready, occ, out_data);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_bubble();
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (c == 0) || (c == 3);
         in_wr    = 1'b1;
         in_wa    = (c == 0) ? 3'd1 : 3'd2;
         in_data  = (c == 0) ? 16'hA0A0 : 16'hB0B0;
         tick();
      end
      in_valid = 1'b0;
      q_addr   = 3'd2;
      #1;
      checks++; if (occ !== 3'd2) begin errors++; $display("FAIL bubble_occ got=%0d exp=2", occ); end
      checks++; if (out_valid !== 1'b1 || out_data !== 16'hA0A0) begin
         errors++; $display("FAIL bubble_out got=%0b/%h exp=1/a0a0", out_valid, out_data);
      end
      checks++; if (q_hit !== 1'b1 || q_stage !== 3'd2 || q_data !== 16'hB0B0) begin
         errors++; $display("FAIL bubble_stage got=%0b/%0d/%h exp=1/2/b0b0", q_hit, q_stage, q_data);
      end
   endtask

   task automatic test_flush();
      logic [15:0] exp_kill;
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_wr = 1'b1; in_wa = RA'(k); in_data = W'(16'h3000 + k);
         tick();
      end
      in_valid   = 1'b0;
      flush_mask = 4'b0011;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
      tick();
      flush_mask = '0;
      q_addr     = 3'd1;
      #1;
      checks++; if (occ !== 3'd2 || out_data !== 16'h3000) begin
         errors++; $display("FAIL flush_occ occ=%0d data=%h exp=2/3000", occ, out_data);
      end
      checks++; if (q_hit !== 1'b1 || q_stage !== 3'd2 || q_data !== 16'h3001) begin
         errors++; $display("FAIL flush_keep got=%0b/%0d/%h exp=1/2/3001", q_hit, q_stage, q_data);
      end
      q_addr = 3'd3;
      #1;
      checks++; if (q_hit !== 1'b0) begin errors++; $display("FAIL flush_gone got=%0b exp=0", q_hit); end
`ifdef PIPE_STATS_EN
      exp_kill = 16'd1;
`else
      exp_kill = 16'd0;
`endif
      checks++; if (stat_kill !== exp_kill) begin errors++; $display("FAIL flush_stat got=%0d exp=%0d", stat_kill, exp_kill); end
      // accept into stage 0 while flushing it: handshake completes, entry dropped
      in_valid = 1'b1; in_wr = 1'b1; in_wa = 3'd6; in_data = 16'h3EEE;
      flush_mask = 4'b0001;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_acc_ready got=%0b exp=1", in_ready); end
      tick();
      in_valid = 1'b0; flush_mask = '0; q_addr = 3'd6;
      #1;
      checks++; if (occ !== 3'd2 || q_hit !== 1'b0) begin
         errors++; $display("FAIL flush_acc_drop occ=%0d hit=%0b exp=2/0", occ, q_hit);
      end
   endtask

   task automatic test_hazard();
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_wr = 1'b1; in_wa = 3'd5; in_data = 16'hBBBB; tick();
      in_valid = 1'b1; in_wr = 1'b0; in_wa = 3'd5; in_data = 16'h1234; tick();
      in_valid = 1'b1; in_wr = 1'b1; in_wa = 3'd5; in_data = 16'hAAAA; tick();
      in_valid = 1'b0; tick();
      q_addr = 3'd5;
      #1;
      checks++; if (q_hit !== 1'b1 || q_stage !== 3'd1 || q_data !== 16'hAAAA) begin
         errors++; $display("FAIL hazard_hit got=%0b/%0d/%h exp=1/1/aaaa", q_hit, q_stage, q_data);
      end
      checks++; if (out_data !== 16'hBBBB || occ !== 3'd3) begin
         errors++; $display("FAIL hazard_layout data=%h occ=%0d exp=bbbb/3", out_data, occ);
      end
      q_addr = 3'd6;
      #1;
      checks++; if (q_hit !== 1'b0 || q_stage !== 3'd0 || q_data !== 16'h0000) begin
         errors++; $display("FAIL hazard_miss got=%0b/%0d/%h exp=0/0/0000", q_hit, q_stage, q_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_wr = 1'b1; in_wa = 3'd4; in_data = W'(16'h4000 + i);
         tick();
      end
      rst = 1'b1; in_data = 16'h4FFF; flush_mask = '1;
      tick();
      rst = 1'b0; in_valid = 1'b0; flush_mask = '0; q_addr = 3'd4;
      #1;
      checks++; if (occ !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_state occ=%0d ov=%0b exp=0/0", occ, out_valid);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++; if (out_valid !== 1'b0 || q_hit !== 1'b0) begin
         errors++; $display("FAIL rstmid_retained ov=%0b hit=%0b exp=0/0", out_valid, q_hit);
      end
   endtask

   task automatic test_random();
      int           qs;
      logic [15:0]  exp_st, exp_kl;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst        = ($urandom_range(0, 79) == 0);
         in_valid   = $urandom_range(0, 3) != 0;
         in_data    = W'($urandom);
         in_wr      = $urandom_range(0, 1);
         in_wa      = RA'($urandom);
         out_ready  = $urandom_range(0, 9) < 6;
         flush_mask = ($urandom_range(0, 7) == 0) ? DEPTH'($urandom) : '0;
         q_addr     = RA'($urandom);
         #1;
         qs = m_qstage(q_addr);
         checks++; if (in_ready !== m_ready()) begin
            errors++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, m_ready());
         end
         checks++; if (out_valid !== mv[DEPTH-1] || (mv[DEPTH-1] &&
               (out_data !== md[DEPTH-1] || out_wr !== mwr[DEPTH-1] || out_wa !== mwa[DEPTH-1]))) begin
            errors++; $display("FAIL rnd_out cyc=%0d got=%0b/%h/%0b/%0d exp=%0b/%h/%0b/%0d", cyc,
               out_valid, out_data, out_wr, out_wa, mv[DEPTH-1], md[DEPTH-1], mwr[DEPTH-1], mwa[DEPTH-1]);
         end
         checks++; if (occ !== SW'(m_count())) begin
            errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", cyc, occ, m_count());
         end
         checks++;
         if (qs < 0) begin
            if (q_hit !== 1'b0 || q_stage !== '0 || q_data !== '0) begin
               errors++; $display("FAIL rnd_query_miss cyc=%0d got=%0b/%0d/%h exp=0/0/0000", cyc, q_hit, q_stage, q_data);
            end
         end else if (q_hit !== 1'b1 || q_stage !== SW'(qs) || q_data !== md[qs]) begin
            errors++; $display("FAIL rnd_query_hit cyc=%0d got=%0b/%0d/%h exp=1/%0d/%h", cyc, q_hit, q_stage, q_data, qs, md[qs]);
         end
`ifdef PIPE_STATS_EN
         exp_st = 16'(m_stall);
         exp_kl = 16'(m_kill);
`else
         exp_st = 16'd0;
         exp_kl = 16'd0;
`endif
         checks++; if (stat_stall !== exp_st || stat_kill !== exp_kl) begin
            errors++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stat_stall, stat_kill, exp_st, exp_kl);
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble();
      test_flush();
      test_hazard();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed inter-stage buffers: a DEPTH-stage elastic pipeline register chain carrying a W-bit payload plus register-write tag (wr, wa) per stage.
- Per-stage valid bits, valid/ready backpressure with bubble collapsing, and a per-stage flush mask.
- Combinational hazard/forwarding query port reports the youngest in-flight writer of a given register.
- Sits between the decode and write-back stages; replaces the always-enabled buffers and the hard-wired NOP-injection flush.

Parameters:
- W, 16, payload width (instruction/ALU data word).
- DEPTH, 4, number of pipeline stages (>=2).
- RA, 3, register address width.
- SW, $clog2(DEPTH+1), occupancy count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream presents an entry
- in_ready  out  1  chain accepts the entry this cycle
- in_data  in  W  payload
- in_wr  in  1  entry writes a register
- in_wa  in  RA  destination register
- out_valid  out  1  stage DEPTH-1 holds a valid entry
- out_ready  in  1  downstream takes it this cycle
- out_data  out  W  stage DEPTH-1 payload
- out_wr  out  1  stage DEPTH-1 write flag
- out_wa  out  RA  stage DEPTH-1 destination
- flush_mask  in  DEPTH  bit k kills stage k at the next edge
- q_addr  in  RA  hazard query register
- q_hit  out  1  some valid stage has wr=1 and wa=q_addr
- q_stage  out  SW  lowest (youngest) matching stage index
- q_data  out  W  payload of that stage
- occ  out  SW  number of valid stages (registered)
- stat_stall  out  16  stall counter (optional feature)
- stat_kill  out  16  kill counter (optional feature)

Behaviour:
- One clock; reset is synchronous and active-high. On rst all valid bits clear; occ=0; stat counters=0; payload/tags are don't-care but driven 0. rst overrides flush and handshakes in the same cycle.
- Stage 0 is youngest; stage DEPTH-1 is the output.
- out_valid/out_data/out_wr/out_wa are driven directly from stage DEPTH-1 registers, with no combinational path from the inputs.
- Stage DEPTH-1 advances when out_valid && out_ready.
- Stage k<DEPTH-1 moves into k+1 when k+1 is empty or k+1 advances this cycle (bubble collapsing).
- in_ready = !valid[0] || stage 0 advances. This is combinational from out_ready through the chain; no path from in_valid.
- Acceptance occurs when in_valid && in_ready. The entry lands in stage 0 at the next edge. Latency is DEPTH cycles into an empty, non-stalled chain.
- Flush: next valid[k] is forced 0 when flush_mask[k]=1, discarding whatever would have loaded into k. Content leaving stage k this cycle still moves to k+1 unless flush_mask[k+1].
  - An accept in a cycle with flush_mask[0]=1 is discarded, but in_ready is unchanged: the handshake completes and the entry is dropped.
  - The output handshake is unaffected by flush_mask[DEPTH-1] in the same cycle.
- occ_next = occ + accepted - drained - (number of entries killed by flush). It must always equal popcount(valid).
- Query: combinational from registered state. On multiple matches, the lowest index wins. With no hit, q_stage=0 and q_data=0. Entries with wr=0 never match.
- Full chain with out_ready=0: in_ready=0 and all stages hold their state.
- Empty chain: out_valid=0, q_hit=0.

Optional Feature:
- PIPE_STATS_EN defined:
  - stat_stall increments each cycle in_valid && !in_ready.
  - stat_kill increments by 1 each cycle at least one valid entry is killed by flush.
  - Both counters are 16-bit, saturate at 16'hFFFF, and clear on rst.
- Not defined: the counter logic is compiled out and both ports are tied to 0.

Decomposition:
- Shared package pipe_pkg:
  - default W/RA constants;
  - the stage entry typedef {valid, wr, wa, data};
  - the NOP encoding constant used by flush-to-bubble consumers.
- Sub-module pipe_stage_slot: one stage register with load/hold/kill controls, generated DEPTH times.
- Priority encoder for the query stays inline.

Test Plan:
- Reset, then feed entries 16'h1001..16'h1004 with out_ready=1 -> out_data 16'h1001 appears exactly 4 cycles after its accept, back-to-back with no gaps, occ steady at 4.
- Fill with out_ready=0 -> in_ready drops after 4 accepts, occ=4. Raise out_ready for 1 cycle -> exactly one drain, one accept, in_ready high only in that cycle.
- Bubble collapse: accept on cycles 0 and 3 with out_ready=0 -> by cycle 5 both entries sit in stages 3 and 2, occ=2.
- Flush: chain full, flush_mask=4'b0011 -> next cycle occ=2, stages 0-1 invalid. stat_kill=1 with PIPE_STATS_EN, 0 without.
- Hazard: stage 1 holds wr=1,wa=3'd5,data 16'hAAAA and stage 3 holds wr=1,wa=5,data 16'hBBBB; q_addr=5 -> q_hit=1, q_stage=1, q_data=16'hAAAA. q_addr=6 -> q_hit=0.
- Assert rst mid-stream with in_valid=1 and flush active -> next cycle occ=0, out_valid=0, and the accepted entry is not retained.
